// File: rtl/xor_cipher_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xor_cipher_pkg
// Brief   : Shared types and constants for the XOR block cipher engine.
//           Holds the FSM state encoding, the CPU's legacy key and the
//           encrypt/decrypt mode encodings.
// Revision: 1.0 - initial release
// ============================================================================
package xor_cipher_pkg;

  // Engine sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Legacy key used by the original fixed-key CPU instructions
  localparam logic [18:0] DEFAULT_KEY = 19'h1999F;

  // Mode encodings (only meaningful when chaining is built)
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage : xor_cipher_pkg
`default_nettype wire

// File: rtl/xor_cipher_xform.sv
`default_nettype none
// ============================================================================
// Module  : xor_cipher_xform
// Brief   : Combinational per-word transform. Produces the output word and
//           the next chain value from the read data, key, current chain and
//           mode. Chained (CBC-style) behaviour is built only when the macro
//           XOR_CHAIN_EN is defined; otherwise out = d ^ key.
// Revision: 1.0 - initial release
// ============================================================================
module xor_cipher_xform
  import xor_cipher_pkg::*;
#(
  parameter int DATA_W = 19
) (
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] chain,
  input  logic              mode,
  output logic [DATA_W-1:0] out,
  output logic [DATA_W-1:0] next_chain
);

`ifdef XOR_CHAIN_EN
  // Chained transform: encrypt feeds the ciphertext forward, decrypt feeds
  // the incoming ciphertext forward, so both directions invert each other.
  always_comb begin
    out        = d ^ key ^ chain;
    next_chain = (mode == MODE_DEC) ? d : (d ^ key ^ chain);
  end
`else
  // Plain transform: chain and mode have no effect.
  always_comb begin
    out        = d ^ key;
    next_chain = '0;
  end

  logic unused_xform_inputs;
  assign unused_xform_inputs = ^{chain, mode};
`endif

endmodule : xor_cipher_xform
`default_nettype wire

// File: rtl/xor_block_cipher.sv
`default_nettype none
// ============================================================================
// Module  : xor_block_cipher
// Brief   : Multi-cycle memory-to-memory XOR cipher engine. On a start pulse
//           it walks LEN words from src to dst, one read then one write per
//           word, through a synchronous data-memory port. Optional chained
//           mode is built when the macro XOR_CHAIN_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module xor_block_cipher
  import xor_cipher_pkg::*;
#(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 19,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] iv,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic [DATA_W-1:0]   chain_cur;
  logic                mode_cur;
  logic [DATA_W-1:0]   xf_out;
  logic [DATA_W-1:0]   xf_next_chain;
  logic [ADDR_W-1:0]   idx_ext;

  assign idx_ext = ADDR_W'(idx_q);

`ifdef XOR_CHAIN_EN
  logic [DATA_W-1:0] chain_q, chain_d;
  logic              mode_q, mode_d;

  assign chain_cur = chain_q;
  assign mode_cur  = mode_q;

  // Chain register and latched mode; chain seeds from iv at launch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain_q <= '0;
      mode_q  <= MODE_ENC;
    end else begin
      chain_q <= chain_d;
      mode_q  <= mode_d;
    end
  end

  // Chain next value: load at launch, advance after every written word
  always_comb begin
    chain_d = chain_q;
    mode_d  = mode_q;
    if (state_q == IDLE && start && len != '0) begin
      chain_d = iv;
      mode_d  = mode;
    end else if (state_q == WR) begin
      chain_d = xf_next_chain;
    end
  end
`else
  assign chain_cur = '0;
  assign mode_cur  = MODE_ENC;

  logic unused_chain_inputs;
  assign unused_chain_inputs = ^{iv, mode, xf_next_chain};
`endif

  xor_cipher_xform #(
    .DATA_W (DATA_W)
  ) u_xform (
    .d          (mem_rd_data),
    .key        (key_q),
    .chain      (chain_cur),
    .mode       (mode_cur),
    .out        (xf_out),
    .next_chain (xf_next_chain)
  );

  // State and launch-parameter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
    end
  end

  // Next-state logic: launch in IDLE, alternate RD/WR per word, then DONE
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    key_d   = key_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            len_d   = len;
            key_d   = key;
            idx_d   = '0;
            state_d = RD;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD:   state_d = WR;
      WR: begin
        if (idx_q == len_q - LEN_W'(1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only; idle values are all zero
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    case (state_q)
      RD: begin
        busy        = 1'b1;
        mem_rd_en   = 1'b1;
        mem_rd_addr = src_q + idx_ext;
      end
      WR: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_wr_addr = dst_q + idx_ext;
        mem_wr_data = xf_out;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule : xor_block_cipher
`default_nettype wire

// File: tb/tb_xor_block_cipher.sv
`default_nettype none
// ============================================================================
// Module  : tb_xor_block_cipher
// Brief   : Self-checking bench for xor_block_cipher with a behavioural
//           memory and a word-serial reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_xor_block_cipher;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [18:0] src_addr = '0;
  logic [18:0] dst_addr = '0;
  logic [7:0]  len = '0;
  logic [18:0] key = '0;
  logic [18:0] iv = '0;
  logic        busy, done;
  logic        mem_rd_en, mem_wr_en;
  logic [18:0] mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic [18:0] mem_rd_data = '0;

  logic [18:0] mem     [0:524287];
  logic [18:0] ref_mem [0:524287];

  logic        tb_we = 1'b0;
  logic [18:0] tb_addr = '0;
  logic [18:0] tb_data = '0;

  logic [18:0] rd_log[$];
  logic [18:0] wa_log[$];
  logic [18:0] wd_log[$];
  int          done_cnt = 0;
  int          both_cnt = 0;

  int          tests = 0;
  int          fails = 0;

  xor_block_cipher #(.DATA_W(19), .ADDR_W(19), .LEN_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .len         (len),
    .key         (key),
    .iv          (iv),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data next cycle, bench preload port
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (tb_we)     mem[tb_addr] <= tb_data;
  end

  // Bus monitor sampled mid-cycle
  always @(negedge clk) begin
    if (mem_rd_en) rd_log.push_back(mem_rd_addr);
    if (mem_wr_en) begin
      wa_log.push_back(mem_wr_addr);
      wd_log.push_back(mem_wr_data);
    end
    if (mem_rd_en && mem_wr_en) both_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Preload one word into the memory and the reference image
  task automatic put(input logic [18:0] a, input logic [18:0] v);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = v;
    ref_mem[a] = v;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  function automatic void model_word(input logic [18:0] x, input logic [18:0] k,
                                     input logic [18:0] ch, input logic m,
                                     output logic [18:0] o, output logic [18:0] nc);
`ifdef XOR_CHAIN_EN
    o  = x ^ k ^ ch;
    nc = m ? x : o;
`else
    o  = x ^ k ^ (ch & 19'h0) ^ {18'h0, m & 1'b0};
    nc = ch;
`endif
  endfunction

  task automatic run(input logic [18:0] s, input logic [18:0] d, input logic [7:0] n,
                     input logic [18:0] k, input logic [18:0] v, input logic m,
                     input bit glitch);
    logic [18:0] exp_rd[$];
    logic [18:0] exp_wa[$];
    logic [18:0] exp_wd[$];
    logic [18:0] ch, o, nc, x;
    int nn, rb, wb, db, bb, edges, busy_cnt, done_edge;
    nn = int'(n);
    ch = v;
    for (int i = 0; i < nn; i++) begin
      x = ref_mem[s + 19'(i)];
      model_word(x, k, ch, m, o, nc);
      ref_mem[d + 19'(i)] = o;
      ch = nc;
      exp_rd.push_back(s + 19'(i));
      exp_wa.push_back(d + 19'(i));
      exp_wd.push_back(o);
    end
    rb = rd_log.size(); wb = wa_log.size(); db = done_cnt; bb = both_cnt;
    @(negedge clk);
    src_addr = s; dst_addr = d; len = n; key = k; iv = v; mode = m; start = 1'b1;
    edges = 0; busy_cnt = 0; done_edge = -1;
    while (edges < 2 * nn + 20 && done_edge < 0) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) begin
        start = 1'b0;
        src_addr = 19'($urandom); dst_addr = 19'($urandom);
        key = 19'($urandom); iv = 19'($urandom);
        mode = 1'($urandom); len = 8'($urandom);
      end
      if (glitch && edges == 2) begin start = 1'b1; len = 8'd5; end
      if (glitch && edges == 3) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) done_edge = edges;
    end
    repeat (4) @(negedge clk);
    check("done_latency", done_edge, 2 * nn + 1);
    check("busy_cycles", busy_cnt, 2 * nn);
    check("done_pulses", done_cnt - db, 1);
    check("strobe_overlap", both_cnt - bb, 0);
    check("rd_count", rd_log.size() - rb, nn);
    check("wr_count", wa_log.size() - wb, nn);
    for (int i = 0; i < nn; i++) begin
      if (rb + i < rd_log.size()) check("rd_addr", rd_log[rb + i], exp_rd[i]);
      if (wb + i < wa_log.size()) begin
        check("wr_addr", wa_log[wb + i], exp_wa[i]);
        check("wr_data", wd_log[wb + i], exp_wd[i]);
      end
    end
    for (int i = 0; i < nn; i++)
      check("mem_word", mem[d + 19'(i)], ref_mem[d + 19'(i)]);
  endtask

  initial begin
    logic [18:0] s, d, o, nc, ch;
    logic [7:0]  n;
    bit          found;
    int          wb, db;

    // Reset state
    #1;
    check("rst_strobes", {busy, done, mem_rd_en, mem_wr_en}, 4'b0);
    check("rst_rd_addr", mem_rd_addr, 0);
    check("rst_wr_addr", mem_wr_addr, 0);
    check("rst_wr_data", mem_wr_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single word with the legacy key
    put(19'h10, 19'h0);
    run(19'h10, 19'h20, 8'd1, 19'h1999F, 19'h0, 1'b0, 1'b0);
    check("legacy_key_word", mem[19'h20], 19'h1999F);

`ifdef XOR_CHAIN_EN
    // Chained encrypt then decrypt round trip
    put(19'h10, 19'h1); put(19'h11, 19'h1);
    run(19'h10, 19'h30, 8'd2, 19'h1999F, 19'h0, 1'b0, 1'b0);
    check("cbc_enc0", mem[19'h30], 19'h1999E);
    check("cbc_enc1", mem[19'h31], 19'h0);
    run(19'h30, 19'h40, 8'd2, 19'h1999F, 19'h0, 1'b1, 1'b0);
    check("cbc_dec0", mem[19'h40], 19'h1);
    check("cbc_dec1", mem[19'h41], 19'h1);
`endif

    // In place, run twice to restore
    for (int i = 0; i < 4; i++) put(19'h50 + 19'(i), 19'(i));
    run(19'h50, 19'h50, 8'd4, 19'h1, 19'h0, 1'b0, 1'b0);
    check("inplace0", mem[19'h50], 19'd1);
    check("inplace1", mem[19'h51], 19'd0);
    check("inplace2", mem[19'h52], 19'd3);
    check("inplace3", mem[19'h53], 19'd2);
    run(19'h50, 19'h50, 8'd4, 19'h1, 19'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) check("inplace_restore", mem[19'h50 + 19'(i)], i);

    // Source address wrap past top of memory
    put(19'h7FFFE, 19'h11111); put(19'h7FFFF, 19'h22222);
    put(19'h00000, 19'h33333); put(19'h00001, 19'h44444);
    run(19'h7FFFE, 19'h60, 8'd4, 19'h0F0F0, 19'h0, 1'b0, 1'b0);

    // Zero-length launch, and a start pulsed while busy
    run(19'h70, 19'h80, 8'd0, 19'h12345, 19'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) put(19'h90 + 19'(i), 19'($urandom));
    run(19'h90, 19'hA0, 8'd3, 19'h2AAAA, 19'h0, 1'b0, 1'b1);

    // Randomized runs, some overlapping
    for (int r = 0; r < 8; r++) begin
      s = 19'($urandom);
      d = (r % 2 == 1) ? s + 19'($urandom_range(0, 3)) : 19'($urandom);
      n = 8'($urandom_range(1, 12));
      for (int i = 0; i < int'(n); i++) put(s + 19'(i), 19'($urandom));
      run(s, d, n, 19'($urandom), 19'($urandom), 1'($urandom), 1'b0);
    end

    // Reset in the WR cycle of word 2 of an 8-word run
    for (int i = 0; i < 8; i++) put(19'h100 + 19'(i), 19'h100 + 19'(i));
    put(19'h202, 19'h5A5A5);
    ch = 19'h0;
    for (int i = 0; i < 2; i++) begin
      model_word(ref_mem[19'h100 + 19'(i)], 19'h0BEEF, ch, 1'b0, o, nc);
      ref_mem[19'h200 + 19'(i)] = o;
      ch = nc;
    end
    wb = wa_log.size(); db = done_cnt;
    @(negedge clk);
    src_addr = 19'h100; dst_addr = 19'h200; len = 8'd8; key = 19'h0BEEF;
    iv = 19'h0; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk); #1;
      if (mem_wr_en && mem_wr_addr == 19'h202) found = 1'b1;
    end
    check("rst_reach_wr2", found, 1);
    rst = 1'b0;
    #1;
    check("midrst_strobes", {busy, done, mem_rd_en, mem_wr_en}, 4'b0);
    check("midrst_buses", mem_rd_addr | mem_wr_addr | mem_wr_data, 0);
    repeat (4) @(negedge clk);
    check("midrst_writes", wa_log.size() - wb, 2);
    check("midrst_no_done", done_cnt - db, 0);
    check("midrst_dropped", mem[19'h202], 19'h5A5A5);
    check("midrst_word0", mem[19'h200], ref_mem[19'h200]);
    check("midrst_word1", mem[19'h201], ref_mem[19'h201]);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) put(19'h300 + 19'(i), 19'($urandom));
    run(19'h300, 19'h400, 8'd5, 19'h1999F, 19'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_xor_block_cipher
`default_nettype wire
